// File: rtl/dma_xfer_ctrl.sv
// Burst transfer sequencer: loads the address counter, then steps it once per acknowledged word.
// Optional macro DMA_WRAP_EN: let the address wrap at FF/00 instead of flagging err.
module dma_xfer_ctrl #(
  parameter int AW  = 8,
  parameter int WCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           dir,
  input  logic [AW-1:0]  addr_init,
  input  logic [WCW-1:0] count_init,
  input  logic           abort,
  input  logic           ack,
  input  logic [AW-1:0]  ctr_q,
  output logic           req,
  output logic [AW-1:0]  mem_addr,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [WCW-1:0] remaining,
  output logic           ctr_pl,
  output logic           ctr_enc,
  output logic           ctr_inc,
  output logic           ctr_dec,
  output logic           ctr_cin,
  output logic [AW-1:0]  ctr_di
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_GAP, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           dir_q, dir_d;
  logic [AW-1:0]  ctr_di_q, ctr_di_d;
  logic [WCW-1:0] remaining_q, remaining_d;
  logic           err_q, err_d;
  logic           wrap_block;

`ifdef DMA_WRAP_EN
  assign wrap_block = 1'b0;
`else
  // A step past FF (ascending) or 00 (descending) would wrap; treat it as an error.
  assign wrap_block = dir_q ? (ctr_q == '0) : (ctr_q == '1);
`endif

  assign mem_addr  = ctr_q;
  assign err       = err_q;
  assign remaining = remaining_q;
  assign ctr_di    = ctr_di_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    ctr_di_d    = ctr_di_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    req         = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    ctr_pl      = 1'b0;
    ctr_enc     = 1'b0;
    ctr_inc     = 1'b0;
    ctr_dec     = 1'b0;
    ctr_cin     = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d       = dir;
          ctr_di_d    = addr_init;
          remaining_d = count_init;
          err_d       = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        busy   = 1'b1;
        ctr_pl = 1'b1;
        if (abort)                   state_d = S_IDLE;
        else if (remaining_q == '0)  state_d = S_DONE;
        else                         state_d = S_REQ;
      end
      S_REQ: begin
        busy    = 1'b1;
        req     = 1'b1;
        ctr_cin = 1'b0;
        ctr_inc = ~dir_q;
        ctr_dec = dir_q;
        // abort wins over a same-cycle ack, leaving count and counter untouched
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack) begin
          remaining_d = remaining_q - WCW'(1);
          if (remaining_q == WCW'(1)) begin
            state_d = S_DONE;
          end else if (wrap_block) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            ctr_enc = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        busy    = 1'b1;
        state_d = abort ? S_IDLE : S_REQ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      ctr_di_q    <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      ctr_di_q    <= ctr_di_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
- Transfer sequencer for the 8-bit address counter (pl/enc/inc/dec/cin control set).
- Loads a start address into the counter and runs a word-count-limited burst of single-word memory transfers over a req/ack handshake.
- Steps the counter up or down after each acknowledged word, and flags address wrap at the counter's terminal values.
- Sits between the CPU-side command interface and the counter/memory port.

Parameters:
- AW, 8, address/counter width; must match the counter datapath width.
- WCW, 8, word-count register width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- dir  in  1  0 = ascending addresses (inc), 1 = descending (dec); latched on start.
- addr_init  in  AW  start address; latched on start.
- count_init  in  WCW  number of words to transfer; latched on start; 0 = no transfer.
- abort  in  1  cancel burst; honoured in LOAD/REQ/GAP.
- ack  in  1  memory acknowledge; single-cycle pulse, valid only while req=1.
- ctr_q  in  AW  counter dataout (current address).
- req  out  1  memory transfer request.
- mem_addr  out  AW  transfer address; equals ctr_q.
- busy  out  1  high in LOAD, REQ and GAP.
- done  out  1  one-cycle completion pulse.
- err  out  1  wrap error; sticky until next accepted start.
- remaining  out  WCW  words still to transfer.
- ctr_pl, ctr_enc, ctr_inc, ctr_dec  out  1 each  counter controls.
- ctr_cin  out  1  counter carry-in/inhibit.
- ctr_di  out  AW  counter parallel-load data.

Behaviour:
- Reset (async) values:
  - State = IDLE.
  - req, busy, done, err, ctr_pl, ctr_enc, ctr_inc, ctr_dec = 0.
  - ctr_cin = 1 (counter inhibited).
  - ctr_di, remaining, latched dir = 0.
- State machine: IDLE, LOAD, REQ, GAP, DONE. Counter-control outputs are decoded combinationally from state, ack and registers.
- IDLE:
  - start=1 latches dir, addr_init into ctr_di, count_init into remaining; clears err; next state LOAD.
  - start=0 holds IDLE. start is ignored in every other state.
- LOAD (exactly 1 cycle):
  - ctr_pl=1; the counter loads ctr_di at the end of this cycle.
  - Next state is DONE if remaining==0, otherwise REQ.
- REQ:
  - req=1, mem_addr=ctr_q, ctr_cin=0, ctr_inc=~dir, ctr_dec=dir.
  - ack=0: hold REQ.
  - ack=1 with remaining==1: remaining becomes 0; next DONE; ctr_enc stays 0, so the counter keeps the last address.
  - ack=1 with remaining>1 and terminal address (ctr_q==all-ones with dir=0, or ctr_q==0 with dir=1), without wrap permitted: err=1; remaining is decremented; next DONE; ctr_enc=0.
  - ack=1 otherwise: ctr_enc=1 for this cycle only, so the counter steps on the same edge; remaining decrements; next GAP.
- GAP (1 cycle):
  - req=0; ctr_cin=1; next REQ.
  - req therefore drops for exactly one cycle between words.
  - Minimum cadence is 2 cycles per word.
- DONE (1 cycle):
  - done=1, busy=0; next IDLE.
  - err is valid alongside done.
- abort=1 in LOAD, REQ or GAP: next state IDLE, no done pulse, remaining frozen.
  - abort takes priority over a same-cycle ack: the ack is ignored and ctr_enc is forced 0.
- Outside REQ: ctr_enc=0 and ctr_cin=1, so the counter never moves except on an acknowledged step.
- remaining is decremented modulo 2^WCW. It cannot underflow, because a transfer is only issued when remaining≥1.
- Reset mid-burst: immediate return to reset values. The counter value is left untouched; the next start reloads it.

Optional Feature:
- Macro DMA_WRAP_EN.
- Defined: the terminal-address check is removed. An ack at a terminal address with remaining>1 steps the counter normally (FF→00 when ascending, 00→FF when descending). err stays 0, and the burst continues in GAP.
- Undefined: wrap is an error, handled as described in Behaviour (err=1, stop at the terminal address, DONE).

Test Plan:
- start, dir=0, addr_init=0x10, count_init=3, ack one cycle after each req → mem_addr 0x10, 0x11, 0x12; done pulse after the third ack; err=0; ctr_q ends at 0x12; ctr_enc pulsed exactly twice.
- start, dir=1, addr_init=0x05, count_init=2, ack delayed 4 cycles each → req held high through each wait; addresses 0x05 then 0x04; remaining goes 2→1→0.
- start, count_init=0 → LOAD, then DONE: done pulse 2 cycles after start; req never asserted.
- start, dir=0, addr_init=0xFE, count_init=4:
  - without DMA_WRAP_EN → addresses 0xFE, 0xFF; done with err=1; remaining=2.
  - with DMA_WRAP_EN → addresses 0xFE, 0xFF, 0x00, 0x01; err=0.
- abort asserted in the same cycle as the second ack of a 5-word burst → IDLE next cycle; no done pulse; remaining=4; ctr_q unchanged.
- reset asserted asynchronously mid-REQ (between clock edges) → req, busy and ctr_enc drop immediately and ctr_cin goes to 1; a start after reset release runs a fresh burst correctly.
